wb_flush_ctrl: RTL

Pipeline flush and refetch controller at the write-back end of the 5-stage LoongArch core. It watches the instruction leaving the WB pipeline register for an exception, `ertn` or TLB/CSR side-effect, and issues a one-cycle flush to all pipeline registers. It then waits for outstanding instruction-fetch and data-memory transactions to drain, and hands a redirect PC to the fetch stage through a valid/ready handshake.

---
 rtl/wb_ctrl_pkg.sv | 37 +++
 rtl/wb_flush_ctrl_if.sv | 48 ++++
 rtl/outstanding_cnt.sv | 47 ++++
 rtl/wb_flush_ctrl.sv | 103 ++++++++++
 4 files changed

// File: rtl/wb_ctrl_pkg.sv
// Shared types for the write-back flush/refetch controller: FSM state
// encoding, redirect cause, reset PC and the redirect-target selector.
package wb_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_REDIRECT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_EX      = 2'd0,
    CAUSE_ERTN    = 2'd1,
    CAUSE_REFETCH = 2'd2
  } cause_e;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // Refetch resumes at the instruction after the one that changed
  // translation state; the add wraps naturally at 2^32.
  function automatic logic [31:0] redirect_target(
    input cause_e      cause,
    input logic [31:0] ex_entry,
    input logic [31:0] era,
    input logic [31:0] pc
  );
    logic [31:0] tgt;
    case (cause)
      CAUSE_EX:   tgt = ex_entry;
      CAUSE_ERTN: tgt = era;
      default:    tgt = pc + 32'd4;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/wb_flush_ctrl_if.sv
// Bundle between the WB-end flush controller and the rest of the core:
// WB instruction info, fetch/data transaction pulses, flush controls and
// the redirect handshake. master = controller, slave = pipeline side.
interface wb_flush_ctrl_if;

  logic        wb_valid;
  logic        wb_ex;
  logic        wb_is_ertn;
  logic        wb_tlb_or_csr_we;
  logic [31:0] wb_pc;
  logic [31:0] ex_entry;
  logic [31:0] csr_era;
  logic        inst_req_fire;
  logic        inst_resp_fire;
  logic        data_req_fire;
  logic        data_resp_fire;
  logic        redirect_ready;

  logic        flush;
  logic        fetch_hold;
  logic        inst_resp_discard;
  logic        inst_req_block;
  logic        data_req_block;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  modport master (
    input  wb_valid, wb_ex, wb_is_ertn, wb_tlb_or_csr_we, wb_pc,
    input  ex_entry, csr_era,
    input  inst_req_fire, inst_resp_fire, data_req_fire, data_resp_fire,
    input  redirect_ready,
    output flush, fetch_hold, inst_resp_discard,
    output inst_req_block, data_req_block,
    output redirect_valid, redirect_pc, busy
  );

  modport slave (
    output wb_valid, wb_ex, wb_is_ertn, wb_tlb_or_csr_we, wb_pc,
    output ex_entry, csr_era,
    output inst_req_fire, inst_resp_fire, data_req_fire, data_resp_fire,
    output redirect_ready,
    input  flush, fetch_hold, inst_resp_discard,
    input  inst_req_block, data_req_block,
    input  redirect_valid, redirect_pc, busy
  );

endinterface

// File: rtl/outstanding_cnt.sv
// Outstanding-transaction counter: +1 per accepted request, -1 per
// response, saturating at both ends. block = counter full; zero = the
// value being loaded this cycle is zero (lets the FSM see drain in time).
module outstanding_cnt #(
  parameter int OUT_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic resp,
  output logic block,
  output logic zero
);

  localparam logic [OUT_W-1:0] CNT_MAX = '1;
  localparam logic [OUT_W-1:0] CNT_ONE = OUT_W'(1);

  logic [OUT_W-1:0] count;
  logic [OUT_W-1:0] count_nxt;

  // Next count: simultaneous req/resp cancel; clamp at full and at empty.
  always_comb begin
    count_nxt = count;
    if (req && !resp && count != CNT_MAX) begin
      count_nxt = count + CNT_ONE;
    end else if (resp && !req && count != '0) begin
      count_nxt = count - CNT_ONE;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

  assign block = (count == CNT_MAX);
  assign zero  = (count_nxt == '0);

  resp_without_outstanding: assert property (
    @(posedge clk) disable iff (rst) !(resp && !req && count == '0)
  );

endmodule

// File: rtl/wb_flush_ctrl.sv
// Write-back flush and refetch controller. Detects exception / ertn /
// (optionally) TLB-CSR refetch on the retiring instruction, flushes the
// pipeline for one cycle, waits for outstanding fetch and data traffic to
// drain, then offers the redirect PC to fetch over valid/ready.
// Optional feature macro: WB_REFETCH_EN (TLB/CSR writes trigger refetch).
module wb_flush_ctrl
  import wb_ctrl_pkg::*;
#(
  parameter int OUT_W = 3
) (
  input logic             clk,
  input logic             rst,
  wb_flush_ctrl_if.master bus
);

  localparam logic [1:0] S_IDLE     = ST_IDLE;
  localparam logic [1:0] S_FLUSH    = ST_FLUSH;
  localparam logic [1:0] S_DRAIN    = ST_DRAIN;
  localparam logic [1:0] S_REDIRECT = ST_REDIRECT;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] redirect_pc;
  logic        refetch;
  logic        event_hit;
  cause_e      cause;
  logic        inst_zero;
  logic        data_zero;
  logic        drained;

`ifdef WB_REFETCH_EN
  assign refetch = bus.wb_tlb_or_csr_we;
`else
  logic unused_tlb_or_csr_we;
  assign refetch              = 1'b0;
  assign unused_tlb_or_csr_we = bus.wb_tlb_or_csr_we;
`endif

  assign event_hit = bus.wb_valid & (bus.wb_ex | bus.wb_is_ertn | refetch);

  // Cause priority: exception over ertn over refetch.
  always_comb begin
    cause = CAUSE_REFETCH;
    if (bus.wb_ex) begin
      cause = CAUSE_EX;
    end else if (bus.wb_is_ertn) begin
      cause = CAUSE_ERTN;
    end
  end

  outstanding_cnt #(.OUT_W(OUT_W)) u_inst_cnt (
    .clk   (clk),
    .rst   (rst),
    .req   (bus.inst_req_fire),
    .resp  (bus.inst_resp_fire),
    .block (bus.inst_req_block),
    .zero  (inst_zero)
  );

  outstanding_cnt #(.OUT_W(OUT_W)) u_data_cnt (
    .clk   (clk),
    .rst   (rst),
    .req   (bus.data_req_fire),
    .resp  (bus.data_resp_fire),
    .block (bus.data_req_block),
    .zero  (data_zero)
  );

  assign drained = inst_zero & data_zero;

  // Next-state logic; events outside IDLE are ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (event_hit) state_nxt = S_FLUSH;
      S_FLUSH,
      S_DRAIN:    state_nxt = drained ? S_REDIRECT : S_DRAIN;
      S_REDIRECT: if (bus.redirect_ready) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // State and redirect target registers; target captured only on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      redirect_pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && event_hit) begin
        redirect_pc <= redirect_target(cause, bus.ex_entry, bus.csr_era, bus.wb_pc);
      end
    end
  end

  assign bus.flush             = (state == S_FLUSH);
  assign bus.fetch_hold        = (state == S_FLUSH) | (state == S_DRAIN);
  assign bus.inst_resp_discard = (state == S_DRAIN) & bus.inst_resp_fire;
  assign bus.redirect_valid    = (state == S_REDIRECT);
  assign bus.redirect_pc       = redirect_pc;
  assign bus.busy              = (state != S_IDLE);

endmodule
